// File: rtl/jpeg_zz_pkg.sv
// Shared zigzag definitions for the JPEG coefficient path.
// The encoder-side zigzag checker uses the same table, so it must stay bit-identical.
package jpeg_zz_pkg;

    localparam int unsigned ZZ_BLK = 64;

    typedef logic [5:0] zz_idx_t;

    // Entry k is the raster (row-major) position of zigzag scan index k.
    localparam zz_idx_t ZZ2RASTER [ZZ_BLK] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic zz_idx_t zz2raster(input zz_idx_t idx);
        return ZZ2RASTER[idx];
    endfunction

endpackage

// File: rtl/jpeg_zz_rom.sv
// Combinational zigzag-index to raster-index lookup.
module jpeg_zz_rom
    import jpeg_zz_pkg::*;
(
    input  logic [5:0] zz_idx_i,
    output logic [5:0] raster_idx_o
);

    always_comb begin
        raster_idx_o = zz2raster(zz_idx_i);
    end

endmodule

// File: rtl/jpeg_dezigzag_buf.sv
// Ping-pong 8x8 block buffer: writes coefficients in zigzag order, reads them out in raster order.
// One bank fills while the other drains; a bank is handed over only when all 64 entries are present.
module jpeg_dezigzag_buf
    import jpeg_zz_pkg::*;
#(
    parameter int unsigned DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_sob,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_first,
    output logic          out_last,
    input  logic          out_ready
);

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [5:0]    wr_idx_q, wr_idx_d;
    logic [5:0]    rd_idx_q, rd_idx_d;
    logic [1:0]    full_q, full_d;
    logic [DW-1:0] mem_q [2][ZZ_BLK];

    logic          wr_hs;
    logic          rd_hs;
    logic          wr_done;
    logic          rd_done;
    logic [5:0]    zz_eff;
    logic [5:0]    wr_raster;

    assign in_ready  = ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_data  = mem_q[rd_bank_q][rd_idx_q];
    assign out_first = out_valid & (rd_idx_q == 6'd0);
    assign out_last  = out_valid & (rd_idx_q == 6'd63);

    assign wr_hs = in_valid & in_ready;
    assign rd_hs = out_valid & out_ready;

    // A start-of-block beat restarts the scan, silently dropping any partial block.
    assign zz_eff  = in_sob ? 6'd0 : wr_idx_q;
    assign wr_done = wr_hs & (zz_eff == 6'd63);
    assign rd_done = rd_hs & (rd_idx_q == 6'd63);

    jpeg_zz_rom u_zz_rom (
        .zz_idx_i     (zz_eff),
        .raster_idx_o (wr_raster)
    );

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        full_d    = full_q;

        if (wr_hs) begin
            wr_idx_d = zz_eff + 6'd1;
            if (wr_done) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // Write completion needs an empty bank and read completion a full one,
        // so both updates never target the same flag.
        if (rd_hs) begin
            rd_idx_d = rd_idx_q + 6'd1;
            if (rd_done) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= 6'd0;
            rd_idx_q  <= 6'd0;
            full_q    <= 2'b00;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            full_q    <= full_d;
        end
    end

    // Storage carries no reset; the full flags alone decide what is visible.
    always_ff @(posedge clk) begin
        if (wr_hs) begin
            mem_q[wr_bank_q][wr_raster] <= in_data;
        end
    end

endmodule

// File: tb/tb_jpeg_dezigzag_buf.sv
// Self-checking bench for jpeg_dezigzag_buf against a block-level inverse-zigzag model.
module tb_jpeg_dezigzag_buf;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_sob;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_first;
    logic          out_last;
    logic          out_ready;

    jpeg_dezigzag_buf #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sob    (in_sob),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: zigzag scan order derived by walking anti-diagonals.
    int            zz2r [64];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] cur_blk [64];
    int            wr_cnt = 0;
    int            blocks_done = 0;

    logic          o_v, o_f, o_l, o_rdy;
    logic [DW-1:0] o_d;
    logic          e_v, e_f, e_l, e_rdy;
    logic [DW-1:0] e_d;
    logic          hs_in, hs_out;
    logic [DW+3:0] obs, exv;

    task automatic build_zigzag();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz2r[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz2r[k] = r * 8 + (s - r); k++; end
            end
        end
    endtask

    task automatic model_write(input logic [DW-1:0] d, input logic sob);
        logic [DW-1:0] ras [64];
        if (sob) wr_cnt = 0;
        cur_blk[wr_cnt] = d;
        wr_cnt++;
        if (wr_cnt == 64) begin
            for (int k = 0; k < 64; k++) ras[zz2r[k]] = cur_blk[k];
            for (int r = 0; r < 64; r++) exp_q.push_back(ras[r]);
            wr_cnt = 0;
            blocks_done++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        wr_cnt = 0;
    endtask

    // One clock: sample DUT and model expectations mid-cycle, then advance the model.
    task automatic tick();
        int sz;
        @(negedge clk);
        o_v = out_valid; o_f = out_first; o_l = out_last; o_rdy = in_ready; o_d = out_data;
        sz    = exp_q.size();
        e_v   = (sz != 0);
        e_d   = e_v ? exp_q[0] : '0;
        e_f   = e_v && (sz % 64 == 0);
        e_l   = e_v && (sz % 64 == 1);
        e_rdy = ((sz + 63) / 64) < 2;
        obs   = {o_v, o_rdy, o_f, o_l, (o_v ? o_d : {DW{1'b0}})};
        exv   = {e_v, e_rdy, e_f, e_l, e_d};
        hs_in  = in_valid && o_rdy;
        hs_out = o_v && out_ready;
        if (hs_out && exp_q.size() != 0) void'(exp_q.pop_front());
        if (hs_in) model_write(in_data, in_sob);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sob = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_tests++;
        if ({out_valid, out_first, out_last} !== 3'b000) begin
            n_fail++; $display("FAIL reset_out_flags got %b want 000", {out_valid, out_first, out_last});
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_ramp();
        logic [DW-1:0] seen [64];
        int idx [10] = '{0, 1, 2, 3, 8, 9, 16, 17, 24, 63};
        int val [10] = '{0, 1, 5, 6, 2, 4, 3, 8, 9, 63};
        int n_out = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 160 && n_out < 64; c++) begin
            in_valid = (c < 64); in_data = DW'(c); in_sob = (c == 0);
            tick();
            n_tests++;
            if (obs !== exv) begin
                n_fail++; $display("FAIL ramp_cycle%0d got %h want %h", c, obs, exv);
            end
            if (hs_out) begin seen[n_out] = o_d; n_out++; end
        end
        in_valid = 1'b0;
        n_tests++;
        if (n_out != 64) begin
            n_fail++; $display("FAIL ramp_count got %0d want 64", n_out);
        end
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (seen[idx[i]] !== DW'(val[i])) begin
                n_fail++; $display("FAIL ramp_r%0d got %0d want %0d", idx[i], seen[idx[i]], val[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int beats = 0, n_out = 0, first_c = -1, last_c = -1, drops = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 400 && n_out < 192; c++) begin
            in_valid = (beats < 192); in_data = DW'($urandom); in_sob = (beats % 64 == 0);
            tick();
            n_tests++;
            if (obs !== exv) begin
                n_fail++; $display("FAIL b2b_cycle%0d got %h want %h", c, obs, exv);
            end
            if (in_valid && !o_rdy) drops++;
            if (hs_in) beats++;
            if (hs_out) begin
                if (first_c < 0) first_c = c;
                last_c = c; n_out++;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (drops != 0) begin n_fail++; $display("FAIL b2b_ready_drops got %0d want 0", drops); end
        n_tests++;
        if (n_out != 192) begin n_fail++; $display("FAIL b2b_count got %0d want 192", n_out); end
        n_tests++;
        if (last_c - first_c != 191) begin
            n_fail++; $display("FAIL b2b_span got %0d want 191", last_c - first_c);
        end
    endtask

    task automatic test_backpressure();
        int beats = 0, n_out = 0, c_hs = -1, c_rdy = -1;
        out_ready = 1'b0;
        for (int c = 0; c < 150; c++) begin
            in_valid = 1'b1; in_data = DW'($urandom); in_sob = (beats % 64 == 0);
            tick();
            n_tests++;
            if (obs !== exv) begin
                n_fail++; $display("FAIL bp_fill_cycle%0d got %h want %h", c, obs, exv);
            end
            if (hs_in) beats++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (beats != 128) begin n_fail++; $display("FAIL bp_accepted got %0d want 128", beats); end
        out_ready = 1'b1;
        for (int c = 0; c < 200 && n_out < 128; c++) begin
            tick();
            n_tests++;
            if (obs !== exv) begin
                n_fail++; $display("FAIL bp_drain_cycle%0d got %h want %h", c, obs, exv);
            end
            if (o_rdy && c_rdy < 0) c_rdy = c;
            if (hs_out) begin
                n_out++;
                if (n_out == 64) c_hs = c;
            end
        end
        n_tests++;
        if (n_out != 128) begin n_fail++; $display("FAIL bp_count got %0d want 128", n_out); end
        n_tests++;
        if (c_rdy != c_hs + 1) begin
            n_fail++; $display("FAIL bp_ready_rise got cycle %0d want %0d", c_rdy, c_hs + 1);
        end
    endtask

    task automatic test_resync();
        logic [DW-1:0] first_val = '0;
        int beats = 0, n_out = 0, stale = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 300 && n_out < 64; c++) begin
            in_valid = (beats < 84);
            if (beats < 20) begin
                in_data = DW'(12'h100 + beats); in_sob = (beats == 0);
            end else if (beats == 20) begin
                in_data = DW'(12'h7FF); in_sob = 1'b1;
            end else begin
                in_data = DW'(beats - 20); in_sob = 1'b0;
            end
            tick();
            n_tests++;
            if (obs !== exv) begin
                n_fail++; $display("FAIL resync_cycle%0d got %h want %h", c, obs, exv);
            end
            if (hs_in) beats++;
            if (hs_out) begin
                if (n_out == 0) first_val = o_d;
                if (o_d >= DW'(12'h100) && o_d < DW'(12'h114)) stale++;
                n_out++;
            end
        end
        in_valid = 1'b0; in_sob = 1'b0;
        n_tests++;
        if (first_val !== DW'(12'h7FF)) begin
            n_fail++; $display("FAIL resync_r0 got %h want 7ff", first_val);
        end
        n_tests++;
        if (stale != 0) begin n_fail++; $display("FAIL resync_stale got %0d want 0", stale); end
    endtask

    task automatic test_reset_mid();
        int beats = 0, n_out = 0;
        out_ready = 1'b0;
        while (beats < 96) begin
            in_valid = 1'b1; in_data = DW'($urandom); in_sob = (beats % 64 == 0);
            tick();
            if (hs_in) beats++;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rstmid_flags got %b want 01", {out_valid, in_ready});
        end
        model_reset();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1; beats = 0;
        for (int c = 0; c < 200; c++) begin
            in_valid = (beats < 64); in_data = DW'($urandom); in_sob = (beats == 0);
            tick();
            n_tests++;
            if (obs !== exv) begin
                n_fail++; $display("FAIL rstmid_cycle%0d got %h want %h", c, obs, exv);
            end
            if (hs_in) beats++;
            if (hs_out) n_out++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (n_out != 64) begin n_fail++; $display("FAIL rstmid_count got %0d want 64", n_out); end
    endtask

    task automatic test_random();
        int n_out = 0, base_blocks, base_q, bad = 0;
        bit done = 0;
        base_blocks = blocks_done;
        base_q = exp_q.size();
        for (int c = 0; c < 90000 && !done; c++) begin
            in_valid  = (blocks_done - base_blocks < 1000) && ($urandom % 16 != 0);
            in_data   = DW'($urandom);
            in_sob    = (wr_cnt == 0) ? 1'($urandom) : ($urandom % 512 == 0);
            out_ready = ($urandom % 16 != 0);
            tick();
            n_tests++;
            if (obs !== exv) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL random_cycle%0d got %h want %h", c, obs, exv);
            end
            if (hs_out) n_out++;
            done = (blocks_done - base_blocks == 1000) && (exp_q.size() == 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL random_timeout got %0d blocks want 1000", blocks_done - base_blocks);
        end
        n_tests++;
        if (n_out != 64000 + base_q) begin
            n_fail++; $display("FAIL random_count got %0d want %0d", n_out, 64000 + base_q);
        end
    endtask

    initial begin
        build_zigzag();
        test_reset();
        test_ramp();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
